nibble_serial_sat_addsub: RTL

//  Multi-cycle sequencer for signed saturating ADD/SUB and PADDSB (four independent 4-bit saturating adds).

---
 rtl/nibble_serial_sat_addsub_if.sv | 25 ++
 rtl/nibble_serial_sat_addsub.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_sat_addsub_if.sv
// Start/busy/done handshake and operand/result bus for the nibble-serial
// saturating add/sub unit. The requester uses the master modport, the
// arithmetic unit uses the slave modport.
interface nibble_serial_sat_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, err
    );
endinterface

// File: rtl/nibble_serial_sat_addsub.sv
// Multi-cycle signed saturating ADD / SUB / PADDSB unit. A single 4-bit
// add/sub slice plus a carry register processes one nibble per cycle, LSB
// nibble first. Operands are shifted right through the slice and the slice
// output is shifted into a shadow register from the top, so after NSTEP
// steps the shadow holds the whole sum in place. The result and error flag
// are held until the next completion.
module nibble_serial_sat_addsub #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_sat_addsub_if.slave bus
);

    localparam int NSTEP = WIDTH / 4;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_PADD = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    // IDLE plus one run state; the nibble step N0..N(NSTEP-1) is held in step_q.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CW-1:0]    LAST_STEP = CW'(NSTEP - 1);
    localparam logic [WIDTH-1:0] SAT_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [0:0]       state_q;
    logic [CW-1:0]    step_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] shadow_q;
    logic             carry_q;
    logic             sticky_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic             done_q;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic             cin;
    logic [4:0]       sum5;
    logic             nib_ovf;
    logic [3:0]       nib_out;
    logic [WIDTH+3:0] shift_cat;
    logic [WIDTH-1:0] shadow_next;
    logic             last_step;
    logic [WIDTH-1:0] final_val;
    logic             final_err;

    // Shared nibble slice: operand conditioning, add, per-nibble overflow and
    // the completion value that is committed when leaving the last step.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so no
        // path can leave it unassigned and infer a latch.
        nib_a       = a_sh_q[3:0];
        nib_b       = (op_q == OP_SUB) ? ~b_sh_q[3:0] : b_sh_q[3:0];
        cin         = (op_q == OP_PADD) ? 1'b0 : carry_q;
        sum5        = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, cin};
        // For SUB the inverted B makes this the a/b-sign-differs rule; on the
        // top nibble it is exactly the full-width ADD/SUB overflow condition.
        nib_ovf     = (nib_a[3] == nib_b[3]) && (sum5[3] != nib_a[3]);
        nib_out     = sum5[3:0];
        if (op_q == OP_PADD && nib_ovf) begin
            nib_out = nib_a[3] ? 4'h8 : 4'h7;
        end
        shift_cat   = {nib_out, shadow_q};
        shadow_next = shift_cat[WIDTH+3:4];
        last_step   = (step_q == LAST_STEP);

        final_val   = shadow_next;
        final_err   = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                final_err = nib_ovf;
                if (nib_ovf) begin
                    final_val = nib_a[3] ? SAT_NEG : SAT_POS;
                end
            end
            OP_PADD: begin
                final_err = sticky_q | nib_ovf;
            end
            OP_ILL: begin
                final_val = '0;
                final_err = 1'b1;
            end
            default: begin
                final_val = '0;
                final_err = 1'b1;
            end
        endcase
    end

    // Sequencer: accept in IDLE, one nibble per cycle, commit on the last step.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values of the others, matching the hardware.
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            op_q     <= OP_ADD;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            shadow_q <= '0;
            carry_q  <= 1'b0;
            sticky_q <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        a_sh_q   <= bus.a;
                        b_sh_q   <= bus.b;
                        shadow_q <= '0;
                        carry_q  <= (bus.op == OP_SUB);
                        sticky_q <= 1'b0;
                        step_q   <= '0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q   <= a_sh_q >> 4;
                    b_sh_q   <= b_sh_q >> 4;
                    shadow_q <= shadow_next;
                    carry_q  <= sum5[4];
                    sticky_q <= sticky_q | nib_ovf;
                    step_q   <= step_q + 1'b1;
                    if (last_step) begin
                        result_q <= final_val;
                        err_q    <= final_err;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        bus.busy   = (state_q == ST_RUN);
        bus.done   = done_q;
        bus.result = result_q;
        bus.err    = err_q;
    end

endmodule
